// File: rtl/pipeline_hazard_unit.sv
// Hazard / forwarding controller for the in-order pipeline.
// A small scoreboard shadows the stages after decode. From it and the decode
// instruction this block derives the load-use stall, the redirect flush/bubble,
// the forwarding selects and two saturating performance counters.

// Per-stage comparator: checks one scoreboard entry against both decode sources.
module phu_stage_cmp #(
    parameter int REG_ADDR_W = 6,
    parameter bit EARLY      = 1'b0   // entry's load data is not ready yet
) (
    input  logic                  ent_valid,
    input  logic [REG_ADDR_W-1:0] ent_dst,
    input  logic                  ent_wr,
    input  logic                  ent_load,
    input  logic                  src_ok_1,
    input  logic [REG_ADDR_W-1:0] src_reg_1,
    input  logic                  src_ok_2,
    input  logic [REG_ADDR_W-1:0] src_reg_2,
    output logic                  match_1,
    output logic                  match_2,
    output logic                  load_use
);
    logic live;

    // Match each qualified source against a live writing entry
    always_comb begin
        live     = ent_valid & ent_wr;
        match_1  = src_ok_1 & live & (ent_dst == src_reg_1);
        match_2  = src_ok_2 & live & (ent_dst == src_reg_2);
        load_use = EARLY & ent_load & (match_1 | match_2);
    end
endmodule

module pipeline_hazard_unit #(
    parameter int REG_ADDR_W = 6,
    parameter int NUM_STAGES = 3,
    parameter int LOAD_STAGE = 1,
    parameter int ZERO_REG   = 1,
    parameter int COUNT_W    = 32,
    localparam int SEL_W     = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  d_valid,
    input  logic [REG_ADDR_W-1:0] d_src_reg_1,
    input  logic                  d_src_used_1,
    input  logic [REG_ADDR_W-1:0] d_src_reg_2,
    input  logic                  d_src_used_2,
    input  logic [REG_ADDR_W-1:0] d_dst_reg,
    input  logic                  d_reg_write,
    input  logic                  d_mem_to_reg,
    input  logic                  x_redirect,
    output logic                  stall,
    output logic                  f2d_flush,
    output logic                  d2x_bubble,
    output logic [SEL_W-1:0]      fwd_sel_1,
    output logic [SEL_W-1:0]      fwd_sel_2,
    output logic [COUNT_W-1:0]    stall_count,
    output logic [COUNT_W-1:0]    flush_count
);
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dst;
        logic                  wr;
        logic                  load;
    } entry_t;

    // Entry 0 = X, entry NUM_STAGES-1 = last writeback stage
    entry_t sb [NUM_STAGES];

    logic [NUM_STAGES-1:0] match_1, match_2, load_use;
    logic                  src_ok_1, src_ok_2, stall_raw;

    // Qualify sources: real instruction, source read, not the hardwired zero register
    always_comb begin
        src_ok_1 = d_valid & d_src_used_1 & ~((ZERO_REG != 0) && (d_src_reg_1 == '0));
        src_ok_2 = d_valid & d_src_used_2 & ~((ZERO_REG != 0) && (d_src_reg_2 == '0));
    end

    for (genvar j = 0; j < NUM_STAGES; j++) begin : g_cmp
        phu_stage_cmp #(
            .REG_ADDR_W (REG_ADDR_W),
            .EARLY      (j < LOAD_STAGE)
        ) u_cmp (
            .ent_valid (sb[j].valid),
            .ent_dst   (sb[j].dst),
            .ent_wr    (sb[j].wr),
            .ent_load  (sb[j].load),
            .src_ok_1  (src_ok_1),
            .src_reg_1 (d_src_reg_1),
            .src_ok_2  (src_ok_2),
            .src_reg_2 (d_src_reg_2),
            .match_1   (match_1[j]),
            .match_2   (match_2[j]),
            .load_use  (load_use[j])
        );
    end

    // Youngest producer wins: scan oldest to youngest so the lowest index overrides
    always_comb begin
        fwd_sel_1 = '0;
        fwd_sel_2 = '0;
        for (int j = NUM_STAGES - 1; j >= 0; j--) begin
            if (match_1[j]) fwd_sel_1 = SEL_W'(j + 1);
            if (match_2[j]) fwd_sel_2 = SEL_W'(j + 1);
        end
    end

    // Redirect squashes the decode instruction, so it overrides any load-use stall
    always_comb begin
        stall_raw  = |load_use;
        f2d_flush  = x_redirect;
        stall      = ~x_redirect & stall_raw;
        d2x_bubble = x_redirect | stall_raw;
    end

    // Shift the scoreboard; a bubble enters X as an invalid entry, the oldest retires
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int j = 0; j < NUM_STAGES; j++) sb[j] <= '0;
        end else begin
            sb[0] <= d2x_bubble ? entry_t'('0)
                                : entry_t'{d_valid, d_dst_reg, d_reg_write, d_mem_to_reg};
            for (int j = 1; j < NUM_STAGES; j++) sb[j] <= sb[j-1];
        end
    end

    // Saturating performance counters
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != '1))      stall_count <= stall_count + 1'b1;
            if (x_redirect && (flush_count != '1)) flush_count <= flush_count + 1'b1;
        end
    end
endmodule
